// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions used by the fetch stage.
package rv32_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DROP = 2'b11
  } fetch_state_e;

  // One fetched instruction together with the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // Force an address onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus.
interface fetch_unit_if;
  import rv32_pkg::*;

  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_gnt;
  logic            im_rvalid;
  logic [XLEN-1:0] im_rdata;

  // Fetch side drives requests, memory side answers
  modport master (output im_req, im_addr, input im_gnt, im_rvalid, im_rdata);
  modport slave  (input im_req, im_addr, output im_gnt, im_rvalid, im_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// 1-entry holding register for a response that arrives while IF/ID is stalled.
module fetch_skid_buf
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic       take,
  input  fetch_pkt_t load_pkt,
  output logic       full,
  output fetch_pkt_t pkt
);

  // Clear beats load beats take; load and take never coincide in practice
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      pkt  <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      pkt  <= load_pkt;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: fetch PC, single-outstanding memory
// handshake, skid buffer and the IF/ID pipeline register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = rv32_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master im,
  input  logic         stall_d,
  input  logic         flush_d,
  input  logic         br_taken,
  input  logic [31:0]  br_target,
  output logic [31:0]  instr_d,
  output logic [31:0]  pc_d,
  output logic [31:0]  pc_plus4_d,
  output logic         valid_d
);
  import rv32_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc_f;      // next address to request
  logic [XLEN-1:0] req_pc;    // address of the outstanding request
  logic [XLEN-1:0] br_pc;

  logic       resp_ok, ifid_load, kill;
  logic       skid_full, skid_load, skid_take;
  logic       src_vld;
  fetch_pkt_t skid_pkt, resp_pkt, src_pkt;

  assign br_pc = word_align(br_target);

  // Responses only count while a live request is outstanding; this is what
  // makes a response arriving after reset harmless.
  assign resp_ok   = (state == WAIT) && im.im_rvalid;
  assign ifid_load = !valid_d || !stall_d;
  assign kill      = br_taken || flush_d;

  // A response landing in the same cycle as a flush or redirect is younger
  // than the squashed instruction, so it is dropped along with it.
  assign skid_load = resp_ok && !ifid_load && !kill;
  assign skid_take = skid_full && ifid_load;

  assign resp_pkt = '{instr: im.im_rdata, pc: req_pc};
  assign src_pkt  = skid_full ? skid_pkt : resp_pkt;
  assign src_vld  = skid_full || resp_ok;

  // Request lines decode registered state only; holding off while the skid
  // is full guarantees there is always room for the next response.
  assign im.im_req  = (state == REQ) && !skid_full;
  assign im.im_addr = pc_f;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (kill),
    .load     (skid_load),
    .take     (skid_take),
    .load_pkt (resp_pkt),
    .full     (skid_full),
    .pkt      (skid_pkt)
  );

  // Fetch FSM and PC: one request in flight, redirects squash it via DROP
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_f   <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          state <= REQ;
          if (br_taken) pc_f <= br_pc;
        end
        REQ: begin
          if (im.im_req && im.im_gnt) begin
            req_pc <= pc_f;
            pc_f   <= br_taken ? br_pc : pc_f + 32'd4;
            state  <= br_taken ? DROP : WAIT;
          end else if (br_taken) begin
            pc_f <= br_pc;
          end
        end
        WAIT: begin
          if (br_taken) pc_f <= br_pc;
          // If the response shows up with the redirect it is already gone,
          // so there is nothing left to drop.
          if (im.im_rvalid)  state <= REQ;
          else if (br_taken) state <= DROP;
        end
        DROP: begin
          if (br_taken) pc_f <= br_pc;
          if (im.im_rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // IF/ID register: skid first, then a fresh response, else a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (kill) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (ifid_load) begin
      if (src_vld) begin
        instr_d    <= src_pkt.instr;
        pc_d       <= src_pkt.pc;
        pc_plus4_d <= src_pkt.pc + 32'd4;
        valid_d    <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small latency-programmable memory.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_d, flush_d, br_taken;
  logic [31:0] br_target;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit_if im_if();

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .im         (im_if.master),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
  );

  always #5 clk = ~clk;

  // Memory model: grants immediately, answers lat cycles after the grant
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return a ^ 32'hC0DE_0000;
    endcase
  endfunction

  logic        pend  = 1'b0;
  logic [1:0]  cnt   = '0;
  logic [31:0] paddr = '0;
  int          lat   = 1;

  assign im_if.im_gnt    = im_if.im_req;
  assign im_if.im_rvalid = pend && (cnt == 2'd0);
  assign im_if.im_rdata  = im_if.im_rvalid ? mem_word(paddr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (im_if.im_req === 1'b1 && im_if.im_gnt === 1'b1) begin
      pend  <= 1'b1;
      cnt   <= 2'(lat - 1);
      paddr <= im_if.im_addr;
    end else if (pend) begin
      if (cnt == 2'd0) pend <= 1'b0;
      else             cnt  <= cnt - 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall_d = 1'b0; flush_d = 1'b0; br_taken = 1'b0; br_target = '0;
    tick(); tick();
    chk("rst_req",   32'(im_if.im_req), 32'd0);
    chk("rst_addr",  im_if.im_addr, 32'h0);
    chk("rst_valid", 32'(valid_d), 32'd0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc",    pc_d, 32'h0);
    chk("rst_pc4",   pc_plus4_d, 32'h0);
    rst = 1'b0;

    // Latency-1 memory: two sequential fetches
    tick();
    chk("f0_req",  32'(im_if.im_req), 32'd1);
    chk("f0_addr", im_if.im_addr, 32'h0);
    tick();
    chk("f0_notyet", 32'(valid_d), 32'd0);
    tick();
    chk("f0_instr", instr_d, 32'h0050_0093);
    chk("f0_pc",    pc_d, 32'h0);
    chk("f0_pc4",   pc_plus4_d, 32'h4);
    chk("f0_valid", 32'(valid_d), 32'd1);
    chk("f1_addr",  im_if.im_addr, 32'h4);
    tick(); tick();
    chk("f1_instr", instr_d, 32'h0010_0113);
    chk("f1_pc",    pc_d, 32'h4);
    chk("f1_pc4",   pc_plus4_d, 32'h8);

    // Stall 3 cycles; word at 0x8 parks in the skid buffer
    stall_d = 1'b1;
    tick(); tick();
    chk("stl_req_off", 32'(im_if.im_req), 32'd0);
    chk("stl_hold_i",  instr_d, 32'h0010_0113);
    tick();
    chk("stl_hold_i2", instr_d, 32'h0010_0113);
    chk("stl_hold_pc", pc_d, 32'h4);
    chk("stl_valid",   32'(valid_d), 32'd1);
    chk("stl_req_off2", 32'(im_if.im_req), 32'd0);
    stall_d = 1'b0;
    tick();
    chk("skid_instr", instr_d, 32'hC0DE_0008);
    chk("skid_pc",    pc_d, 32'h8);
    chk("skid_req",   32'(im_if.im_req), 32'd1);
    chk("skid_addr",  im_if.im_addr, 32'hC);
    tick(); tick();
    chk("post_instr", instr_d, 32'hC0DE_000C);
    chk("post_pc",    pc_d, 32'hC);

    // Redirect while WAIT: response for 0x10 must be dropped
    lat = 3;
    tick();
    br_taken = 1'b1; br_target = 32'h0000_0102;
    tick();
    br_taken = 1'b0; lat = 1;
    chk("br_valid", 32'(valid_d), 32'd0);
    chk("br_instr", instr_d, NOP);
    chk("br_req",   32'(im_if.im_req), 32'd0);
    tick();
    chk("drop_valid", 32'(valid_d), 32'd0);
    tick();
    chk("drop_valid2", 32'(valid_d), 32'd0);
    chk("br_req2",     32'(im_if.im_req), 32'd1);
    chk("br_addr",     im_if.im_addr, 32'h100);
    tick(); tick();
    chk("br_instr2", instr_d, 32'hC0DE_0100);
    chk("br_pc2",    pc_d, 32'h100);
    chk("br_pc4",    pc_plus4_d, 32'h104);

    // Flush pulse: bubble, PC sequence unchanged
    flush_d = 1'b1;
    tick();
    flush_d = 1'b0;
    chk("fl_valid", 32'(valid_d), 32'd0);
    chk("fl_instr", instr_d, NOP);
    tick();
    chk("fl_next_i",  instr_d, 32'hC0DE_0104);
    chk("fl_next_pc", pc_d, 32'h104);

    // Redirect coincident with a grant, to the top of memory (low bits ignored)
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    tick();
    br_taken = 1'b0;
    chk("wr_valid", 32'(valid_d), 32'd0);
    chk("wr_req",   32'(im_if.im_req), 32'd0);
    tick();
    chk("wr_req2",  32'(im_if.im_req), 32'd1);
    chk("wr_addr",  im_if.im_addr, 32'hFFFF_FFFC);
    chk("wr_valid2", 32'(valid_d), 32'd0);
    tick(); tick();
    chk("wr_instr", instr_d, 32'h3F21_FFFC);
    chk("wr_pc",    pc_d, 32'hFFFF_FFFC);
    chk("wr_pc4",   pc_plus4_d, 32'h0);
    chk("wr_next",  im_if.im_addr, 32'h0);
    chk("wr_nreq",  32'(im_if.im_req), 32'd1);

    // Reset during WAIT; late response must be ignored
    lat = 2;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; lat = 1;
    chk("mr_valid", 32'(valid_d), 32'd0);
    chk("mr_addr",  im_if.im_addr, 32'h0);
    chk("mr_req",   32'(im_if.im_req), 32'd0);
    tick();
    chk("mr_valid2", 32'(valid_d), 32'd0);
    chk("mr_req2",   32'(im_if.im_req), 32'd1);
    chk("mr_addr2",  im_if.im_addr, 32'h0);
    tick(); tick();
    chk("mr_instr", instr_d, 32'h0050_0093);
    chk("mr_pc",    pc_d, 32'h0);
    chk("mr_valid3", 32'(valid_d), 32'd1);

    // Flush and stall together: flush wins
    stall_d = 1'b1; flush_d = 1'b1;
    tick();
    stall_d = 1'b0; flush_d = 1'b0;
    chk("fs_valid", 32'(valid_d), 32'd0);
    chk("fs_instr", instr_d, NOP);
    tick();
    chk("fs_next_i",  instr_d, 32'h0010_0113);
    chk("fs_next_pc", pc_d, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch (IF) stage of the RV32I 5-stage pipeline. Produces the instruction words that the decode-stage control unit consumes.
- Holds the fetch PC and issues word requests to instruction memory over a request/grant/response handshake, with at most one request outstanding.
- Delivers instr/PC through the IF/ID register and handles decode stalls, flushes and branch/jump redirects from the branch control unit.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0013, word driven on instr_d when the IF/ID slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- im_req  out  1  fetch request valid.
- im_addr  out  32  word address of the request; stable while im_req=1 and im_gnt=0.
- im_gnt  in  1  request accepted this cycle.
- im_rvalid  in  1  response word valid; arrives at least 1 cycle after im_gnt.
- im_rdata  in  32  response instruction word.
- stall_d  in  1  decode holds the IF/ID register.
- flush_d  in  1  invalidate the IF/ID register (bubble).
- br_taken  in  1  redirect the fetch PC to br_target.
- br_target  in  32  redirect address; bits [1:0] are ignored (forced to 0).
- instr_d  out  32  IF/ID instruction word.
- pc_d  out  32  IF/ID PC.
- pc_plus4_d  out  32  IF/ID PC+4, used for the J-type link write.
- valid_d  out  1  IF/ID slot holds a real instruction.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc_f=RESET_PC, state=IDLE, im_req=0, im_addr=RESET_PC.
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, skid buffer empty.
  - Reset asserted mid-transaction abandons any outstanding request. The state goes to IDLE and a late im_rvalid is ignored: it is only accepted in WAIT/DROP.
- FSM states: IDLE, REQ, WAIT, DROP.
  - IDLE: one cycle after reset, then REQ.
  - REQ: im_req=1, im_addr=pc_f. On im_gnt: pc_f += 4, next state WAIT.
  - REQ stays in REQ (im_req=0) while the skid buffer is full.
  - WAIT: im_req=0. On im_rvalid, deliver {im_rdata, PC of the request}, then go to REQ.
  - DROP: im_req=0. On im_rvalid, discard the word, then go to REQ.
- Delivery:
  - The IF/ID register loads when (valid_d=0 or stall_d=0).
  - Source priority: skid buffer first, then a fresh response.
  - If a response arrives and IF/ID cannot load, the word goes into the 1-entry skid buffer.
  - If IF/ID loads and no word is available, valid_d=0 and instr_d=NOP_INSTR.
- Fetch latency: request granted at cycle T with im_rvalid at T+k means instr_d is valid from T+k+1, provided stall_d=0.
- Redirect (br_taken=1):
  - pc_f = {br_target[31:2],2'b00}.
  - valid_d cleared, skid buffer cleared.
  - In WAIT, or in REQ with im_gnt the same cycle: next state DROP.
  - Otherwise: next state REQ at the new address.
  - Redirect takes priority over stall_d and flush_d.
- flush_d=1 without br_taken: valid_d cleared and skid buffer cleared. PC and FSM are unaffected.
- flush_d and stall_d both high: the flush wins.
- PC arithmetic: 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0x0000_0000. pc_plus4_d is computed with the same wrap.
- Simultaneous im_rvalid and br_taken: the response word is discarded and the redirect is applied.
- Stalled outputs: instr_d, pc_d and pc_plus4_d are held stable while stall_d=1 and valid_d=1.

Decomposition:
- Shared package rv32_pkg:
  - NOP_INSTR and RESET_PC constants.
  - Fetch FSM state encoding (IDLE=2'b00, REQ=2'b01, WAIT=2'b10, DROP=2'b11).
  - XLEN=32.
- One sub-module: fetch_skid_buf, a 1-entry {instr, pc} holding register with load/take/clear and a full flag.

Test Plan:
- Reset then a zero-latency-1 memory (gnt same cycle, rvalid next cycle) returning 0x00500093, 0x00100113 → im_addr 0x0, 0x4; instr_d/pc_d = 0x00500093/0x0, then 0x00100113/0x4; valid_d=1; pc_plus4_d=0x4, then 0x8.
- stall_d held 3 cycles while a response arrives → instr_d/pc_d frozen; next word sits in the skid buffer; im_req=0 while the buffer is full; after release, words are delivered in order with none lost or duplicated.
- br_taken with br_target=0x0000_0102 while in WAIT → state DROP; returning word is discarded; next im_addr=0x0000_0100; valid_d=0 for the redirect cycle.
- flush_d pulse with valid_d=1 → valid_d=0, instr_d=0x00000013; PC sequence continues unchanged.
- PC at 0xFFFF_FFFC → pc_plus4_d=0x0000_0000 and the next im_addr=0x0000_0000.
- rst asserted in WAIT with rvalid arriving the following cycle → response ignored; im_addr=RESET_PC; valid_d=0; fetch restarts cleanly.
